multicycle_main_control: RTL and testbench
==========================================

// Module: multicycle_main_control
// PURPOSE
//  Multicycle MIPS main control FSM; the producer of the 3-bit ALUOp consumed by the ALU control decoder.
//  Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK from the instruction opcode.
//  Drives datapath enables and counts retired instructions.
//  Waits on a memory ready handshake.
// PARAMETERS
//  COUNT_W  16  width of retired-instruction counter
// PORTS
//  clk          in   1        rising-edge clock (single clock domain)
//  reset        in   1        synchronous, active-high reset
//  Opcode       in   6        IR[31:26], valid from DECODE onward
//  mem_ready    in   1        memory completes access this cycle
//  ALUOp        out  3        111 R-type, 100 add, 101 or, 001 sub (branch), 110 inc
//  PCWrite      out  1        unconditional PC load
//  PCWriteCond  out  1        conditional PC load (branch)
//  BranchNE     out  1        0 = take on Zero (BEQ), 1 = take on !Zero (BNE)
//  IorD         out  1        0 = PC addresses memory, 1 = ALUOut
//  MemRead      out  1        memory read request
//  MemWrite     out  1        memory write request
//  IRWrite      out  1        load instruction register
//  RegDst       out  1        1 = rd, 0 = rt
//  MemtoReg     out  1        1 = MDR, 0 = ALUOut to register file
//  RegWrite     out  1        register file write enable
//  ALUSrcA      out  1        0 = PC, 1 = rs
//  ALUSrcB      out  2        00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  PCSource     out  2        00 ALU result, 01 ALUOut, 10 jump target
//  retire       out  1        one-cycle pulse when an instruction completes
//  instr_count  out  COUNT_W  retired instruction count
//  illegal_op   out  1        sticky illegal-opcode flag (see CONFIGURATION)
// BEHAVIOUR
//  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP, TRAP.
//  - Outputs are decoded from the state register. IRWrite and PCWrite in FETCH are additionally gated by mem_ready.
//  - Any output not listed for a state is 0.
//  - Reset: state=FETCH, instr_count=0, illegal_op=0. Reset overrides any state, including mid-instruction and TRAP.
//  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00.
//    If mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Otherwise hold in FETCH.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=100 (branch target to ALUOut). Next state by Opcode:
//    - 000000 R -> EXEC_R
//    - 001000 ADDI, 001101 ORI, 011100 INC -> EXEC_I
//    - 100011 LW, 101011 SW -> MEMADR
//    - 000100 BEQ, 000101 BNE -> BRANCH
//    - 000010 J -> JUMP
//    - other -> see CONFIGURATION
//  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111 -> ALUWB with RegDst=1.
//  - EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=100 (ADDI), 101 (ORI) or 110 (INC) -> ALUWB with RegDst=0.
//    The opcode is latched into an internal register in DECODE so ALUWB's RegDst does not depend on Opcode staying stable.
//  - ALUWB: RegWrite=1, MemtoReg=0, retire -> FETCH.
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=100 -> MEMRD (LW) or MEMWR (SW).
//  - MEMRD: MemRead=1, IorD=1. Hold until mem_ready, then -> MEMWB.
//  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, retire -> FETCH.
//  - MEMWR: MemWrite=1, IorD=1. Hold until mem_ready, then retire -> FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01, BranchNE=(opcode==BNE), retire -> FETCH.
//  - JUMP: PCWrite=1, PCSource=10, retire -> FETCH.
//  - Cycle counts with mem_ready=1 throughout: R/I = 4, LW = 5, SW = 4, BEQ/BNE/J = 3.
//  - instr_count increments by 1 on every retire and wraps from 2^COUNT_W-1 to 0. retire is never asserted in TRAP.
//  - mem_ready is ignored in states other than FETCH, MEMRD and MEMWR.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    - Unknown opcode in DECODE -> TRAP.
//    - TRAP: all enables 0, illegal_op=1; stays in TRAP until reset.
//  ILLEGAL_TRAP_EN undefined:
//    - Unknown opcode is a NOP: DECODE -> FETCH with retire=1.
//    - illegal_op is tied to 0 and TRAP is unreachable.
// TESTING
//  1. R-type (Opcode=000000), mem_ready=1: states F,D,EXEC_R,ALUWB. ALUOp=111 in EXEC_R. RegWrite=1, RegDst=1 in ALUWB. instr_count 0->1.
//  2. LW, mem_ready held 0 for 3 cycles in MEMRD: MemRead=1, IorD=1 held 3 extra cycles. MEMWB then asserts MemtoReg=1, RegWrite=1.
//  3. BEQ then BNE: ALUOp=001, PCWriteCond=1, PCSource=01 in BRANCH. BranchNE=0 then 1. Each takes 3 cycles.
//  4. ORI and INC: ALUOp=101 and 110 respectively in EXEC_I. ALUSrcB=10, RegDst=0 at writeback.
//  5. Reset asserted in MEMWR: next cycle state=FETCH, MemWrite=0, instr_count=0, no retire pulse.
//  6. Opcode=111111: with ILLEGAL_TRAP_EN, illegal_op=1 and stuck until reset. Without it, returns to FETCH and instr_count+1.
//     Also preload count to 2^16-1, retire once -> instr_count=0.

Source files
------------

// File: rtl/multicycle_main_control_if.sv
// rtl/multicycle_main_control_if.sv - control/datapath signal bundle for the multicycle main control FSM
interface multicycle_main_control_if #(
    parameter int COUNT_W = 16
);
    logic [5:0]         Opcode;
    logic               mem_ready;
    logic [2:0]         ALUOp;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               BranchNE;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegDst;
    logic               MemtoReg;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSource;
    logic               retire;
    logic [COUNT_W-1:0] instr_count;
    logic               illegal_op;

    modport master (
        input  Opcode, mem_ready,
        output ALUOp, PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite,
               IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               retire, instr_count, illegal_op
    );

    modport slave (
        output Opcode, mem_ready,
        input  ALUOp, PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite,
               IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               retire, instr_count, illegal_op
    );
endinterface

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multicycle MIPS main control FSM with retired-instruction counter
// Define ILLEGAL_TRAP_EN to trap unknown opcodes (sticky illegal_op); otherwise they retire as NOPs.
module multicycle_main_control #(
    parameter int COUNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_main_control_if.master bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_INC  = 6'b011100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               retire_s;

    function automatic logic is_known(input logic [5:0] op);
        case (op)
            OP_R, OP_ADDI, OP_ORI, OP_INC, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J: is_known = 1'b1;
            default:              is_known = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    // Opcode is captured in DECODE so later states never depend on IR staying stable.
    always_comb begin
        op_d    = (state_q == S_DECODE) ? bus.Opcode : op_q;
        count_d = retire_s ? count_q + COUNT_W'(1) : count_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_R:                    state_d = S_EXEC_R;
                    OP_ADDI, OP_ORI, OP_INC: state_d = S_EXEC_I;
                    OP_LW, OP_SW:            state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:          state_d = S_BRANCH;
                    OP_J:                    state_d = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:                 state_d = S_TRAP;
`else
                    default:                 state_d = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.ALUOp       = 3'b000;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.BranchNE    = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegDst      = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.PCSource    = 2'b00;
        bus.illegal_op  = 1'b0;
        retire_s        = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 3'b100;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                bus.ALUOp   = 3'b100;
`ifndef ILLEGAL_TRAP_EN
                retire_s    = !is_known(bus.Opcode);
`endif
            end
            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 3'b111;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                case (op_q)
                    OP_ORI:  bus.ALUOp = 3'b101;
                    OP_INC:  bus.ALUOp = 3'b110;
                    default: bus.ALUOp = 3'b100;
                endcase
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = (op_q == OP_R);
                retire_s     = 1'b1;
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = 3'b100;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                retire_s     = 1'b1;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                retire_s     = bus.mem_ready;
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 3'b001;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.BranchNE    = (op_q == OP_BNE);
                retire_s        = 1'b1;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                retire_s     = 1'b1;
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                bus.illegal_op = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign bus.retire      = retire_s;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - scoreboard bench for multicycle_main_control
module tb_multicycle_main_control;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_INC  = 6'b011100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic [2:0] aluop;
        logic       pcw, pcwc, bne, iord, mrd, mwr, irw, regdst, m2r, regw, srca;
        logic [1:0] srcb, pcsrc;
        logic       retire, illegal;
    } ctrl_t;

    typedef struct {
        ctrl_t       ctrl;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_cnt = '0;
    exp_t q[$];

    multicycle_main_control_if #(.COUNT_W(16)) m_if ();
    multicycle_main_control_if #(.COUNT_W(3))  w_if ();

    assign w_if.Opcode    = m_if.Opcode;
    assign w_if.mem_ready = m_if.mem_ready;

    multicycle_main_control #(.COUNT_W(16)) dut (.clk(clk), .reset(reset), .bus(m_if.master));
    multicycle_main_control #(.COUNT_W(3))  dut_w (.clk(clk), .reset(reset), .bus(w_if.master));

    always #5 clk = ~clk;

    function automatic ctrl_t c_fetch(input logic mr);
        ctrl_t c = '0;
        c.mrd = 1'b1; c.srcb = 2'b01; c.aluop = 3'b100; c.irw = mr; c.pcw = mr;
        return c;
    endfunction
    function automatic ctrl_t c_decode(input logic ret);
        ctrl_t c = '0;
        c.srcb = 2'b11; c.aluop = 3'b100; c.retire = ret;
        return c;
    endfunction
    function automatic ctrl_t c_exec_r();
        ctrl_t c = '0;
        c.srca = 1'b1; c.aluop = 3'b111;
        return c;
    endfunction
    function automatic ctrl_t c_exec_i(input logic [2:0] op3);
        ctrl_t c = '0;
        c.srca = 1'b1; c.srcb = 2'b10; c.aluop = op3;
        return c;
    endfunction
    function automatic ctrl_t c_aluwb(input logic rd);
        ctrl_t c = '0;
        c.regw = 1'b1; c.regdst = rd; c.retire = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_memadr();
        ctrl_t c = '0;
        c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 3'b100;
        return c;
    endfunction
    function automatic ctrl_t c_memrd();
        ctrl_t c = '0;
        c.mrd = 1'b1; c.iord = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_memwb();
        ctrl_t c = '0;
        c.regw = 1'b1; c.m2r = 1'b1; c.retire = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_memwr(input logic mr);
        ctrl_t c = '0;
        c.mwr = 1'b1; c.iord = 1'b1; c.retire = mr;
        return c;
    endfunction
    function automatic ctrl_t c_branch(input logic ne);
        ctrl_t c = '0;
        c.srca = 1'b1; c.aluop = 3'b001; c.pcwc = 1'b1; c.pcsrc = 2'b01; c.bne = ne; c.retire = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_jump();
        ctrl_t c = '0;
        c.pcw = 1'b1; c.pcsrc = 2'b10; c.retire = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_trap();
        ctrl_t c = '0;
        c.illegal = 1'b1;
        return c;
    endfunction

    // One clock of stimulus: drive inputs, queue what the DUT must show this cycle.
    task automatic step(input ctrl_t e, input logic [5:0] op, input logic mr, input logic rst, input string name);
        exp_t x;
        m_if.Opcode    = op;
        m_if.mem_ready = mr;
        reset          = rst;
        x.ctrl = e;
        x.cnt  = exp_cnt;
        x.name = name;
        q.push_back(x);
        @(posedge clk);
        #1;
        if (rst)             exp_cnt = '0;
        else if (e.retire)   exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic run_j(input string name);
        step(c_fetch(1'b1), OP_J, 1'b1, 1'b0, {name, "_fetch"});
        step(c_decode(1'b0), OP_J, 1'b1, 1'b0, {name, "_decode"});
        step(c_jump(), OP_J, 1'b1, 1'b0, {name, "_jump"});
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t  e;
            ctrl_t got;
            e   = q.pop_front();
            got = {m_if.ALUOp, m_if.PCWrite, m_if.PCWriteCond, m_if.BranchNE, m_if.IorD,
                   m_if.MemRead, m_if.MemWrite, m_if.IRWrite, m_if.RegDst, m_if.MemtoReg,
                   m_if.RegWrite, m_if.ALUSrcA, m_if.ALUSrcB, m_if.PCSource, m_if.retire,
                   m_if.illegal_op};
            checks++;
            if (got !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl got=%05h exp=%05h", e.name, got, e.ctrl);
            end
            checks++;
            if (m_if.instr_count !== e.cnt) begin
                errors++;
                $display("FAIL %s instr_count got=%0d exp=%0d", e.name, m_if.instr_count, e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_if.Opcode    = OP_R;
        m_if.mem_ready = 1'b0;
        reset          = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // R-type, 4 cycles
        step(c_fetch(1'b1), OP_R, 1'b1, 1'b0, "r_fetch");
        step(c_decode(1'b0), OP_R, 1'b1, 1'b0, "r_decode");
        step(c_exec_r(), OP_R, 1'b1, 1'b0, "r_exec");
        step(c_aluwb(1'b1), OP_R, 1'b1, 1'b0, "r_wb");

        // LW with a fetch stall and three memory wait cycles
        step(c_fetch(1'b0), OP_LW, 1'b0, 1'b0, "lw_fetch_wait");
        step(c_fetch(1'b1), OP_LW, 1'b1, 1'b0, "lw_fetch");
        step(c_decode(1'b0), OP_LW, 1'b0, 1'b0, "lw_decode");
        step(c_memadr(), OP_LW, 1'b0, 1'b0, "lw_memadr");
        for (int i = 0; i < 3; i++) step(c_memrd(), OP_LW, 1'b0, 1'b0, "lw_memrd_wait");
        step(c_memrd(), OP_LW, 1'b1, 1'b0, "lw_memrd");
        step(c_memwb(), OP_LW, 1'b0, 1'b0, "lw_memwb");

        // BEQ then BNE, 3 cycles each
        step(c_fetch(1'b1), OP_BEQ, 1'b1, 1'b0, "beq_fetch");
        step(c_decode(1'b0), OP_BEQ, 1'b1, 1'b0, "beq_decode");
        step(c_branch(1'b0), OP_BEQ, 1'b1, 1'b0, "beq_branch");
        step(c_fetch(1'b1), OP_BNE, 1'b1, 1'b0, "bne_fetch");
        step(c_decode(1'b0), OP_BNE, 1'b1, 1'b0, "bne_decode");
        step(c_branch(1'b1), OP_BNE, 1'b1, 1'b0, "bne_branch");

        // ORI, INC, ADDI; opcode changes after DECODE to prove it is latched
        step(c_fetch(1'b1), OP_ORI, 1'b1, 1'b0, "ori_fetch");
        step(c_decode(1'b0), OP_ORI, 1'b1, 1'b0, "ori_decode");
        step(c_exec_i(3'b101), OP_R, 1'b1, 1'b0, "ori_exec");
        step(c_aluwb(1'b0), OP_R, 1'b1, 1'b0, "ori_wb");
        step(c_fetch(1'b1), OP_INC, 1'b1, 1'b0, "inc_fetch");
        step(c_decode(1'b0), OP_INC, 1'b1, 1'b0, "inc_decode");
        step(c_exec_i(3'b110), OP_INC, 1'b1, 1'b0, "inc_exec");
        step(c_aluwb(1'b0), OP_INC, 1'b1, 1'b0, "inc_wb");
        step(c_fetch(1'b1), OP_ADDI, 1'b1, 1'b0, "addi_fetch");
        step(c_decode(1'b0), OP_ADDI, 1'b1, 1'b0, "addi_decode");
        step(c_exec_i(3'b100), OP_ADDI, 1'b1, 1'b0, "addi_exec");
        step(c_aluwb(1'b0), OP_ADDI, 1'b1, 1'b0, "addi_wb");

        // SW with one wait cycle, then J
        step(c_fetch(1'b1), OP_SW, 1'b1, 1'b0, "sw_fetch");
        step(c_decode(1'b0), OP_SW, 1'b1, 1'b0, "sw_decode");
        step(c_memadr(), OP_SW, 1'b1, 1'b0, "sw_memadr");
        step(c_memwr(1'b0), OP_SW, 1'b0, 1'b0, "sw_memwr_wait");
        step(c_memwr(1'b1), OP_SW, 1'b1, 1'b0, "sw_memwr");
        run_j("j1");

        // Reset in the middle of a store
        step(c_fetch(1'b1), OP_SW, 1'b1, 1'b0, "rst_sw_fetch");
        step(c_decode(1'b0), OP_SW, 1'b1, 1'b0, "rst_sw_decode");
        step(c_memadr(), OP_SW, 1'b1, 1'b0, "rst_sw_memadr");
        step(c_memwr(1'b0), OP_SW, 1'b0, 1'b1, "rst_sw_memwr");
        step(c_fetch(1'b0), OP_R, 1'b0, 1'b0, "rst_after_fetch");

        // Unknown opcode
        step(c_fetch(1'b1), OP_BAD, 1'b1, 1'b0, "bad_fetch");
`ifdef ILLEGAL_TRAP_EN
        step(c_decode(1'b0), OP_BAD, 1'b1, 1'b0, "bad_decode");
        step(c_trap(), OP_R, 1'b1, 1'b0, "bad_trap0");
        step(c_trap(), OP_J, 1'b0, 1'b0, "bad_trap1");
        step(c_trap(), OP_R, 1'b1, 1'b1, "bad_trap_rst");
        step(c_fetch(1'b0), OP_R, 1'b0, 1'b0, "bad_after_rst");
`else
        step(c_decode(1'b1), OP_BAD, 1'b1, 1'b0, "bad_decode_nop");
        step(c_fetch(1'b0), OP_R, 1'b0, 1'b0, "bad_after_nop");
`endif

        // Counter wrap on a 3-bit instance: eight jumps bring it back to zero
        step(c_fetch(1'b0), OP_J, 1'b0, 1'b1, "wrap_rst");
        for (int i = 0; i < 8; i++) begin
            logic [2:0] want;
            want = 3'(i + 1);
            run_j("wrap_j");
            checks++;
            if (w_if.instr_count !== want) begin
                errors++;
                $display("FAIL wrap_count_%0d got=%0d exp=%0d", i, w_if.instr_count, want);
            end
        end

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
